// File: rtl/bmp_pixel_reader_if.sv
// Bundles the frame-start control, frame-memory read port and RGB pixel stream
// of bmp_pixel_reader. Suffixes are named from the reader's point of view.
`default_nettype none

interface bmp_pixel_reader_if #(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 12
);
  logic              start_i;
  logic [ADDR_W-1:0] base_addr_i;
  logic [DIM_W-1:0]  width_i;
  logic [DIM_W-1:0]  height_i;
  logic              busy_o;
  logic              done_o;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_rd_o;
  logic [7:0]        mem_data_i;

  logic [7:0]        pix_r_o;
  logic [7:0]        pix_g_o;
  logic [7:0]        pix_b_o;
  logic              pix_valid_o;
  logic              pix_ready_i;
  logic              pix_sol_o;
  logic              pix_eol_o;
  logic              pix_eof_o;

  modport master (
    input  start_i, base_addr_i, width_i, height_i, mem_data_i, pix_ready_i,
    output busy_o, done_o, mem_addr_o, mem_rd_o,
    output pix_r_o, pix_g_o, pix_b_o, pix_valid_o, pix_sol_o, pix_eol_o, pix_eof_o
  );

  modport slave (
    output start_i, base_addr_i, width_i, height_i, mem_data_i, pix_ready_i,
    input  busy_o, done_o, mem_addr_o, mem_rd_o,
    input  pix_r_o, pix_g_o, pix_b_o, pix_valid_o, pix_sol_o, pix_eol_o, pix_eof_o
  );
endinterface

`default_nettype wire

// File: rtl/bmp_pixel_reader.sv
// Streams a bottom-up, 4-byte-padded 24-bit BMP pixel array out of byte-wide
// frame memory as top-first RGB pixels with SOL/EOL/EOF markers.
`default_nettype none

module bmp_pixel_reader #(
  parameter int ADDR_W = 20,
  parameter int DIM_W  = 12
) (
  input  logic                clk_i,
  input  logic                rst_i,
  bmp_pixel_reader_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_OUT   = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [ADDR_W-1:0] row_addr_q, row_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [DIM_W-1:0]  width_q, width_d;
  logic [DIM_W-1:0]  height_q, height_d;
  logic [DIM_W-1:0]  col_q, col_d;
  logic [DIM_W-1:0]  row_q, row_d;
  logic              rd_v_q;
  logic [1:0]        rd_idx_q;
  logic [7:0]        r_q, g_q, b_q;

  logic [ADDR_W-1:0] stride_in;
  logic [ADDR_W-1:0] first_row;
  logic              last_col;
  logic              last_row;

  // Row stride rounds 3*WIDTH up to a multiple of 4; pixel rows are stored bottom-up.
  assign stride_in = (ADDR_W'(bus.width_i) * ADDR_W'(3) + ADDR_W'(3)) & ~ADDR_W'(3);
  assign first_row = bus.base_addr_i
                   + ADDR_W'(bus.height_i - DIM_W'(1)) * stride_in;
  assign last_col  = (col_q == width_q - DIM_W'(1));
  assign last_row  = (row_q == height_q - DIM_W'(1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mem_addr_q <= '0;
      row_addr_q <= '0;
      stride_q   <= '0;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mem_addr_q <= mem_addr_d;
      row_addr_q <= row_addr_d;
      stride_q   <= stride_d;
      width_q    <= width_d;
      height_q   <= height_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    mem_addr_d = mem_addr_q;
    row_addr_d = row_addr_q;
    stride_d   = stride_q;
    width_d    = width_q;
    height_d   = height_q;
    col_d      = col_q;
    row_d      = row_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          width_d    = bus.width_i;
          height_d   = bus.height_i;
          stride_d   = stride_in;
          row_addr_d = first_row;
          mem_addr_d = first_row;
          col_d      = '0;
          row_d      = '0;
          cnt_d      = '0;
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        if (cnt_q == 2'd2) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end else begin
          cnt_d      = cnt_q + 2'd1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      S_WAIT: state_d = S_OUT;
      S_OUT: begin
        if (bus.pix_ready_i) begin
          if (last_col && last_row) begin
            // Leave the address untouched so it holds its last value while idle.
            state_d = S_FIN;
          end else if (last_col) begin
            col_d      = '0;
            row_d      = row_q + DIM_W'(1);
            row_addr_d = row_addr_q - stride_q;
            mem_addr_d = row_addr_q - stride_q;
            state_d    = S_FETCH;
          end else begin
            col_d      = col_q + DIM_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = S_FETCH;
          end
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Read data lags the strobe by one cycle; the tracking bit is cleared by reset
  // so a read in flight at reset time is dropped.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_v_q   <= 1'b0;
      rd_idx_q <= '0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      rd_v_q   <= (state_q == S_FETCH);
      rd_idx_q <= cnt_q;
      if (rd_v_q) begin
        case (rd_idx_q)
          2'd0:    b_q <= bus.mem_data_i;
          2'd1:    g_q <= bus.mem_data_i;
          default: r_q <= bus.mem_data_i;
        endcase
      end
    end
  end

  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_rd_o    = (state_q == S_FETCH);
  assign bus.pix_valid_o = (state_q == S_OUT);
  assign bus.pix_r_o     = r_q;
  assign bus.pix_g_o     = g_q;
  assign bus.pix_b_o     = b_q;
  assign bus.pix_sol_o   = (state_q == S_OUT) && (col_q == '0);
  assign bus.pix_eol_o   = (state_q == S_OUT) && last_col;
  assign bus.pix_eof_o   = (state_q == S_OUT) && last_col && last_row;
  assign bus.busy_o      = (state_q == S_FETCH) || (state_q == S_WAIT) || (state_q == S_OUT);
  assign bus.done_o      = (state_q == S_FIN);

endmodule

`default_nettype wire

// File: tb/tb_bmp_pixel_reader.sv
// Directed self-checking bench for bmp_pixel_reader with a small byte memory model.
`default_nettype none

module tb_bmp_pixel_reader;
  localparam int ADDR_W = 20;
  localparam int DIM_W  = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bmp_pixel_reader_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) bus ();

  bmp_pixel_reader #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [7:0] mem [0:255];
  always @(posedge clk)
    if (bus.mem_rd_o) bus.mem_data_i <= mem[bus.mem_addr_o[7:0]];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [23:0] hs_pix [$];
  logic [2:0]  hs_flg [$];
  int          hs_cyc [$];
  int          rd_addr [$];
  int          rd_cyc [$];
  int          done_cnt, done_cyc, busy_cnt, bad_rd, start_cyc;
  int          n_chk = 0;
  int          n_pass = 0;

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pix_valid_o && bus.pix_ready_i) begin
        hs_pix.push_back({bus.pix_r_o, bus.pix_g_o, bus.pix_b_o});
        hs_flg.push_back({bus.pix_sol_o, bus.pix_eol_o, bus.pix_eof_o});
        hs_cyc.push_back(cyc);
      end
      if (bus.mem_rd_o) begin
        rd_addr.push_back(int'(bus.mem_addr_o));
        rd_cyc.push_back(cyc);
        if (bus.mem_addr_o == 20'h3C || bus.mem_addr_o == 20'h3D ||
            bus.mem_addr_o == 20'h44 || bus.mem_addr_o == 20'h45)
          bad_rd++;
      end
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus.busy_o) busy_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.mem_addr_o, bus.mem_rd_o, bus.pix_r_o, bus.pix_g_o, bus.pix_b_o,
                bus.pix_valid_o, bus.pix_sol_o, bus.pix_eol_o, bus.pix_eof_o,
                bus.busy_o, bus.done_o});
  endfunction

  task automatic clear_log();
    hs_pix.delete(); hs_flg.delete(); hs_cyc.delete();
    rd_addr.delete(); rd_cyc.delete();
    done_cnt = 0; done_cyc = 0; busy_cnt = 0; bad_rd = 0;
  endtask

  task automatic start_frame(input int base, input int w, input int h);
    @(posedge clk); #1;
    bus.base_addr_i = ADDR_W'(base);
    bus.width_i     = DIM_W'(w);
    bus.height_i    = DIM_W'(h);
    bus.start_i     = 1'b1;
    start_cyc       = cyc;
    @(posedge clk); #1;
    bus.start_i     = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_cnt == 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (done_cnt == 0) check("done_timeout", 64'd0, 64'd1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_2x2(input string tag);
    logic [23:0] ep [4] = '{24'h302010, 24'h605040, 24'h908070, 24'hC0B0A0};
    logic [2:0]  ef [4] = '{3'b100, 3'b010, 3'b100, 3'b011};
    check({tag, "_npix"}, 64'(hs_pix.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s_pix%0d", tag, i), (i < hs_pix.size()) ? 64'(hs_pix[i]) : '1, 64'(ep[i]));
      check($sformatf("%s_flg%0d", tag, i), (i < hs_flg.size()) ? 64'(hs_flg[i]) : '1, 64'(ef[i]));
    end
  endtask

  initial begin
    logic [27:0] snap;
    int          n_rd, stall_bad, n;
    int          ea [12] = '{'h3E, 'h3F, 'h40, 'h41, 'h42, 'h43,
                             'h36, 'h37, 'h38, 'h39, 'h3A, 'h3B};

    bus.start_i = 1'b0; bus.base_addr_i = '0; bus.width_i = '0; bus.height_i = '0;
    bus.pix_ready_i = 1'b1;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 6; i++) begin
      mem[8'h3E + i] = 8'(8'h10 * (i + 1));
      mem[8'h36 + i] = 8'(8'h70 + 8'h10 * i);
    end
    for (int i = 0; i < 12; i++) mem[8'h80 + i] = 8'(8'hA0 + i);
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33;
    clear_log();

    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 64'd0);
    rst = 1'b0;

    // 2x2 image with padded rows
    clear_log();
    start_frame('h36, 2, 2);
    wait_done();
    check_2x2("t1");
    check("t1_pad_reads", 64'(bad_rd), 64'd0);
    check("t1_done_cnt", 64'(done_cnt), 64'd1);

    // 4x1 image: latency, pixel interval, contiguous addresses
    clear_log();
    start_frame('h80, 4, 1);
    wait_done();
    check("t2_npix", 64'(hs_pix.size()), 64'd4);
    check("t2_nrd", 64'(rd_addr.size()), 64'd12);
    check("t2_latency", 64'(hs_cyc[0] - rd_cyc[0]), 64'd4);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_interval%0d", i), 64'(hs_cyc[i+1] - hs_cyc[i]), 64'd5);
    for (int i = 0; i < 12; i++)
      check($sformatf("t2_addr%0d", i), 64'(rd_addr[i]), 64'('h80 + i));
    check("t2_pix0", 64'(hs_pix[0]), 64'h00A2A1A0);
    check("t2_pix3", 64'(hs_pix[3]), 64'h00ABAAA9);
    check("t2_flg0", 64'(hs_flg[0]), 64'b100);
    check("t2_flg3", 64'(hs_flg[3]), 64'b011);

    // 2x2 with consumer stall on pixel 2
    clear_log();
    start_frame('h36, 2, 2);
    n = 0;
    while (hs_pix.size() < 1 && n < 50) begin @(posedge clk); #1; n++; end
    bus.pix_ready_i = 1'b0;
    n = 0;
    while (!bus.pix_valid_o && n < 50) begin @(posedge clk); #1; n++; end
    check("t3_valid_seen", 64'(bus.pix_valid_o), 64'd1);
    snap = {bus.pix_r_o, bus.pix_g_o, bus.pix_b_o, bus.pix_sol_o, bus.pix_eol_o,
            bus.pix_eof_o, bus.pix_valid_o};
    n_rd = rd_addr.size();
    stall_bad = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if ({bus.pix_r_o, bus.pix_g_o, bus.pix_b_o, bus.pix_sol_o, bus.pix_eol_o,
           bus.pix_eof_o, bus.pix_valid_o} !== snap) stall_bad++;
    end
    check("t3_stall_hold", 64'(stall_bad), 64'd0);
    check("t3_stall_no_rd", 64'(rd_addr.size()), 64'(n_rd));
    bus.pix_ready_i = 1'b1;
    wait_done();
    check_2x2("t3");
    check("t3_resume", 64'(rd_cyc[6] - hs_cyc[1]), 64'd1);

    // 1x1 image
    clear_log();
    start_frame('h10, 1, 1);
    wait_done();
    check("t4_npix", 64'(hs_pix.size()), 64'd1);
    check("t4_pix", 64'(hs_pix[0]), 64'h00332211);
    check("t4_flg", 64'(hs_flg[0]), 64'b111);
    check("t4_done_cnt", 64'(done_cnt), 64'd1);
    check("t4_busy_cycles", 64'(busy_cnt), 64'd5);
    check("t4_done_cycle", 64'(done_cyc - start_cyc), 64'd6);

    // START during a frame is ignored
    clear_log();
    start_frame('h36, 2, 2);
    repeat (8) @(posedge clk);
    #1;
    bus.base_addr_i = 20'h80; bus.width_i = 12'd4; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    wait_done();
    check_2x2("t5");
    check("t5_nrd", 64'(rd_addr.size()), 64'd12);
    for (int i = 0; i < 12; i++)
      check($sformatf("t5_addr%0d", i), (i < rd_addr.size()) ? 64'(rd_addr[i]) : '1, 64'(ea[i]));
    check("t5_idle_busy", 64'(bus.busy_o), 64'd0);

    // Reset during FETCH of pixel 3, then a fresh frame
    clear_log();
    start_frame('h36, 2, 2);
    n = 0;
    while (rd_addr.size() < 7 && n < 50) begin @(posedge clk); #1; n++; end
    rst = 1'b1;
    #1;
    check("t6_reset_outs", outs(), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    start_frame('h36, 2, 2);
    wait_done();
    check_2x2("t6");
    check("t6_first_addr", 64'(rd_addr[0]), 64'h3E);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/bmp_pixel_reader.md
Name: bmp_pixel_reader

Overview:
- Streams a 24-bit BMP pixel array out of the byte-wide frame memory as an RGB pixel stream, top row first, left to right.
- Handles BMP bottom-up row order and 4-byte row padding, and emits line and frame markers.
- Read-side counterpart of the BMP load path that fills frame memory. It feeds the detection pipeline in `top`.

Parameters:
- ADDR_W, 20, frame memory byte-address width (covers 0x10_0000 bytes).
- DIM_W, 12, width of the image WIDTH and HEIGHT inputs.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  one-cycle pulse that begins a frame; sampled only in IDLE.
- BASE_ADDR  in  ADDR_W  byte address of the first pixel-array byte (bottom row); latched on START.
- WIDTH  in  DIM_W  pixels per row, 1 or more; latched on START.
- HEIGHT  in  DIM_W  rows, 1 or more; latched on START.
- MEM_ADDR  out  ADDR_W  frame memory read address.
- MEM_RD  out  1  read strobe.
- MEM_DATA  in  8  read data; valid the cycle after MEM_RD and sampled on the following edge.
- PIX_R, PIX_G, PIX_B  out  8 each  pixel colour components.
- PIX_VALID  out  1  pixel available.
- PIX_READY  in  1  consumer accepts the pixel.
- PIX_SOL  out  1  pixel is first of its row (qualified by PIX_VALID).
- PIX_EOL  out  1  pixel is last of its row.
- PIX_EOF  out  1  pixel is last of the frame.
- BUSY  out  1  frame in progress.
- DONE  out  1  one-cycle pulse after the last pixel handshake.

Behaviour:
- Reset state: FSM in IDLE, and every output is 0 (MEM_ADDR, MEM_RD, PIX_*, BUSY, DONE). Reset acts immediately and may be asserted mid-frame. A read returning after reset is ignored.
- Row stride: S = (3*WIDTH + 3) & ~3, computed at ADDR_W bits.
- Row address: display row r (0 is top) starts at BASE_ADDR + (HEIGHT-1-r)*S. Pixel c of that row is at row start + 3*c.
- Byte order in memory is B, G, R at increasing addresses. Padding bytes are never read.
- Address arithmetic wraps modulo 2^ADDR_W. Keeping the frame inside the memory is the caller's responsibility.
- FSM states: IDLE, FETCH, WAIT, OUT, FIN.
- IDLE: on START, latch inputs, compute the first row address, set BUSY=1 and go to FETCH.
- FETCH: lasts 3 cycles. MEM_RD=1 with MEM_ADDR = a, a+1, a+2 on consecutive cycles, where a is the current pixel address.
- WAIT: lasts 1 cycle while the last byte returns. B, G and R are captured on the edges 2, 3 and 4 cycles after the first issue.
- Pixel timing: PIX_VALID rises 4 cycles after the first FETCH cycle. No bubble is required inside FETCH.
- OUT: PIX_VALID=1. PIX_R/G/B, SOL, EOL and EOF are stable while PIX_READY=0.
- OUT handshake: when PIX_VALID && PIX_READY on an edge, advance the column. At the end of a row, advance the row and reload a. If the pixel was the last of the frame, go to FIN; otherwise go to FETCH.
- Throughput: the minimum is 1 pixel per 5 cycles, reached with PIX_READY held high.
- FIN: 1 cycle with DONE=1 and BUSY=0, then IDLE. BUSY drops on the same edge that DONE rises.
- START while BUSY is ignored. Latched dimensions do not change mid-frame.
- WIDTH=1 or HEIGHT=1: SOL and EOL are both 1 on a single-column pixel, and EOF is set on the last pixel.
- Reset during OUT drops PIX_VALID asynchronously. The consumer treats the frame as aborted.
- MEM_RD is 0 in all states except FETCH. MEM_ADDR holds its last value when idle.

Test Plan:
1. 2x2 image, BASE=0x36, S=8. Top row at 0x3E holds 10 20 30 40 50 60; bottom row at 0x36 holds 70 80 90 A0 B0 C0; PIX_READY held 1. Required: pixels (R,G,B) = (30,20,10), (60,50,40), (90,80,70), (C0,B0,A0). SOL on pixels 1 and 3, EOL on pixels 2 and 4, EOF on pixel 4. Addresses 0x3C-0x3D and 0x44-0x45 never read. DONE pulses once.
2. WIDTH=4, HEIGHT=1 (S=12, no padding), PIX_READY=1. Required: first PIX_VALID exactly 4 cycles after the first MEM_RD, then pixels every 5 cycles. MEM_ADDR sequence is BASE..BASE+11 with no gaps.
3. Same 2x2 image with PIX_READY low for 7 cycles on pixel 2. Required: outputs hold stable, no MEM_RD during the stall, and fetch resumes the cycle after the handshake.
4. 1x1 image. Required: a single pixel with SOL=EOL=EOF=1, followed by DONE; BUSY high from the cycle after START until DONE.
5. START pulsed again during the frame, with a different WIDTH. Required: ignored; pixel count and addresses match the original dimensions.
6. RESET asserted during FETCH of pixel 3, then a new START. Required: all outputs go to 0 immediately, and the new frame restarts at top row pixel 0 with correct data.
